// File: rtl/fp_mul_arbiter_if.sv
// Bundle of requester, multiplier, response and debug signals for fp_mul_arbiter.
// slave is the arbiter side; master is the side that drives requests and the multiplier result.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(LATENCY + 1);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;

  logic [31:0]           mul_ay;
  logic [31:0]           mul_az;
  logic [31:0]           mul_result;
  logic                  mul_en;
  logic                  mul_clr;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic                  busy;

  logic [ID_W-1:0]       dbg_rr_ptr;
  logic [CNT_W-1:0]      dbg_fifo_count;
  logic [INF_W-1:0]      dbg_inflight;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, resp_ready,
    output req_ready, mul_ay, mul_az, mul_en, mul_clr,
           resp_valid, resp_id, resp_data, busy,
           dbg_rr_ptr, dbg_fifo_count, dbg_inflight
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, resp_ready,
    input  req_ready, mul_ay, mul_az, mul_en, mul_clr,
           resp_valid, resp_id, resp_data, busy,
           dbg_rr_ptr, dbg_fifo_count, dbg_inflight
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one fixed-latency FP multiplier between NUM_REQ requesters,
// with an ID tag pipe alongside the multiplier and an in-order response FIFO.
module fp_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic               clk0,
  input  logic               clr0,
  fp_mul_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int INF_W = $clog2(LATENCY + 1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // req_ready is one-hot on the granted requester and only asserts while a FIFO slot is
  // reserved for the result; resp_valid/resp_ready pop the FIFO head.

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant;
  logic               found;
  logic               credit;
  logic               issue;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;

  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];
  logic [INF_W-1:0]   inflight;

  logic [ID_W+31:0]   mem [FIFO_DEPTH];
  logic [ID_W+31:0]   head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]   occupancy;
  logic               push;
  logic               pop;
  logic               not_empty;

  // First pass searches rr_ptr..NUM_REQ-1, second pass wraps to the low indices.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        found = 1'b1;
        grant = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found = 1'b1;
        grant = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + INF_W'(tag_v[i]);
    end
  end

  // Every issued operation owns a FIFO slot from issue until pop, so a tag never exits into a full FIFO.
  assign occupancy = OCC_W'(inflight) + OCC_W'(fifo_count);
  assign credit    = occupancy < OCC_W'(FIFO_DEPTH);
  assign issue     = clr0 && found && credit;

  assign bus.req_ready = issue ? (NUM_REQ'(1) << grant) : '0;
  assign bus.mul_ay    = issue ? sel_a : '0;
  assign bus.mul_az    = issue ? sel_b : '0;
  assign bus.mul_en    = 1'b1;
  assign bus.mul_clr   = 1'b0;

  always_ff @(posedge clk0 or negedge clr0) begin
    if (!clr0) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Stage LATENCY-1 lines up with mul_result for the operation issued LATENCY cycles earlier.
  always_ff @(posedge clk0 or negedge clr0) begin
    if (!clr0) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= grant;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign push      = tag_v[LATENCY-1];
  assign not_empty = fifo_count != '0;
  assign pop       = not_empty && bus.resp_ready;

  always_ff @(posedge clk0) begin
    if (push) begin
      mem[wr_ptr] <= {tag_id[LATENCY-1], bus.mul_result};
    end
  end

  always_ff @(posedge clk0 or negedge clr0) begin
    if (!clr0) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The storage array is not reset, so the head is masked while the FIFO is empty.
  assign head           = mem[rd_ptr];
  assign bus.resp_valid = not_empty;
  assign bus.resp_id    = not_empty ? head[ID_W+31:32] : '0;
  assign bus.resp_data  = not_empty ? head[31:0] : '0;
  assign bus.busy       = (inflight != '0) || (fifo_count != '0);

  assign bus.dbg_rr_ptr     = rr_ptr;
  assign bus.dbg_fifo_count = fifo_count;
  assign bus.dbg_inflight   = inflight;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: a pipelined multiplier model, a round-robin/credit
// reference model feeding an expected-response queue, and a response monitor that pops it.
module tb_fp_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 4;
  localparam int DEPTH   = 8;
  localparam int ID_W    = 2;

  logic clk0 = 1'b0;
  logic clr0 = 1'b0;
  int   cyc  = 0;
  int   errors = 0;
  int   checks = 0;

  fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)) bus ();

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk0 (clk0),
    .clr0 (clr0),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event within cycle budget (cycle %0d)", name, cyc);
  endtask

  // Operands use 9-bit significands so the single-precision product is exact.
  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)),
            8'($urandom_range(0, 255)), 15'b0};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [8:0]  sx;
    logic [8:0]  sy;
    logic [17:0] p;
    int          e;
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 32'd0;
    sx = {1'b1, x[22:15]};
    sy = {1'b1, y[22:15]};
    p  = sx * sy;
    e  = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[17]) return {x[31] ^ y[31], 8'(e + 1), p[16:0], 6'b0};
    return {x[31] ^ y[31], 8'(e), p[15:0], 7'b0};
  endfunction

  // ---------------- multiplier model ----------------
  logic [31:0] mpipe [LAT];
  always @(posedge clk0) begin
    mpipe[0] <= fmul(bus.mul_ay, bus.mul_az);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.mul_result = mpipe[LAT-1];

  // ---------------- reference model + scoreboard push ----------------
  logic [ID_W+31:0]   exp_q[$];
  int                 grant_log[$];
  int                 hist[$];
  int                 ref_ptr;
  int                 outstanding;
  int                 g;
  int                 c_idx;
  int                 inflight_e;
  bit                 found_e;
  bit                 exp_issue;
  bit                 pop_now;
  logic [NUM_REQ-1:0] exp_ready;
  logic [31:0]        exp_a;
  logic [31:0]        exp_b;

  always @(negedge clk0) begin
    if (!clr0) begin
      chk("req_ready_in_reset", 64'(bus.req_ready), 64'(0));
      ref_ptr     = 0;
      outstanding = 0;
      exp_q.delete();
      grant_log.delete();
      hist.delete();
      for (int k = 0; k < LAT; k++) hist.push_back(0);
    end else begin
      found_e = 1'b0;
      g       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        c_idx = (ref_ptr + k) % NUM_REQ;
        if (!found_e && bus.req_valid[c_idx]) begin
          found_e = 1'b1;
          g       = c_idx;
        end
      end
      exp_issue = found_e && (outstanding < DEPTH);
      exp_ready = exp_issue ? (NUM_REQ'(1) << g) : '0;
      exp_a     = bus.req_a[32*g +: 32];
      exp_b     = bus.req_b[32*g +: 32];
      inflight_e = 0;
      foreach (hist[k]) inflight_e += hist[k];

      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("mul_ay", 64'(bus.mul_ay), 64'(exp_issue ? exp_a : 32'd0));
      chk("mul_az", 64'(bus.mul_az), 64'(exp_issue ? exp_b : 32'd0));
      chk("rr_ptr", 64'(bus.dbg_rr_ptr), 64'(ref_ptr));
      chk("inflight", 64'(bus.dbg_inflight), 64'(inflight_e));
      chk("fifo_count", 64'(bus.dbg_fifo_count), 64'(outstanding - inflight_e));
      chk("busy", 64'(bus.busy), 64'(outstanding != 0));

      pop_now = bus.resp_valid && bus.resp_ready;
      if (exp_issue) begin
        exp_q.push_back({ID_W'(g), fmul(exp_a, exp_b)});
        grant_log.push_back(g);
        ref_ptr = (g + 1) % NUM_REQ;
      end
      outstanding = outstanding + int'(exp_issue) - int'(pop_now);
      void'(hist.pop_front());
      hist.push_back(int'(exp_issue));
    end
  end

  // ---------------- response monitor ----------------
  logic [ID_W+31:0] got_exp;
  always @(negedge clk0) begin
    if (!clr0) begin
      chk("resp_valid_in_reset", 64'(bus.resp_valid), 64'(0));
      chk("busy_in_reset", 64'(bus.busy), 64'(0));
      chk("resp_id_in_reset", 64'(bus.resp_id), 64'(0));
      chk("resp_data_in_reset", 64'(bus.resp_data), 64'(0));
    end else if (bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(bus.resp_valid), 64'(0));
      end else begin
        got_exp = exp_q.pop_front();
        chk("resp_id", 64'(bus.resp_id), 64'(got_exp[ID_W+31:32]));
        chk("resp_data", 64'(bus.resp_data), 64'(got_exp[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic new_ops(input int i);
    bus.req_a[32*i +: 32] = rand_fp();
    bus.req_b[32*i +: 32] = rand_fp();
  endtask

  task automatic do_reset(input int n);
    clr0 = 1'b0;
    repeat (n) tick();
    clr0 = 1'b1;
  endtask

  // Requesters hold valid until accepted; accepted ones get fresh operands.
  task automatic run_cycles(input int n, input bit rand_mode, input logic [NUM_REQ-1:0] vmask);
    logic [NUM_REQ-1:0] acc;
    repeat (n) begin
      @(negedge clk0);
      acc = bus.req_valid & bus.req_ready;
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) new_ops(i);
        if (rand_mode && (acc[i] || !bus.req_valid[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          new_ops(i);
        end
      end
      if (rand_mode) bus.resp_ready = ($urandom_range(0, 3) != 0);
      else           bus.req_valid  = vmask;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_timeout("drain");
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  int n;
  int stale;

  initial begin
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) new_ops(i);

    // All requesters valid from reset: grants rotate 0,1,2,3,...
    bus.req_valid = '1;
    repeat (3) tick();
    chk("mul_en", 64'(bus.mul_en), 64'(1));
    chk("mul_clr", 64'(bus.mul_clr), 64'(0));
    bus.resp_ready = 1'b1;
    clr0 = 1'b1;
    run_cycles(12, 1'b0, '1);
    if (grant_log.size() < 8) fail_timeout("rotate_grants");
    else for (int k = 0; k < 8; k++) chk("rotate_grant", 64'(grant_log[k]), 64'(k % NUM_REQ));
    drain();

    // Single request from requester 2: 2.0 * 3.0 = 6.0, response LATENCY+1 cycles later.
    bus.req_valid = '0;
    do_reset(2);
    bus.req_a[32*2 +: 32] = 32'h4000_0000;
    bus.req_b[32*2 +: 32] = 32'h4040_0000;
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b1;
    n = 0;
    @(negedge clk0);
    while (!bus.req_ready[2] && n < 10) begin
      n++;
      @(negedge clk0);
    end
    if (n >= 10) fail_timeout("single_accept");
    tick();
    bus.req_valid = '0;
    n = 1;
    @(negedge clk0);
    while (!bus.resp_valid && n < 20) begin
      n++;
      @(negedge clk0);
    end
    chk("single_latency", 64'(n), 64'(LAT + 1));
    chk("single_id", 64'(bus.resp_id), 64'(2));
    chk("single_data", 64'(bus.resp_data), 64'h40C0_0000);
    drain();

    // Requesters 1 and 3 with rr_ptr=2: expect 3 then 1.
    clr0 = 1'b0;
    bus.req_valid = 4'b0010;
    repeat (2) tick();
    clr0 = 1'b1;
    tick();
    bus.req_valid = 4'b1010;
    tick();
    tick();
    bus.req_valid = '0;
    if (grant_log.size() != 3) fail_timeout("rr_wrap_count");
    else begin
      chk("rr_first", 64'(grant_log[0]), 64'(1));
      chk("rr_skip_to_3", 64'(grant_log[1]), 64'(3));
      chk("rr_wrap_to_1", 64'(grant_log[2]), 64'(1));
    end
    drain();

    // Backpressure: exactly DEPTH accepts, then a push+pop at fifo_count = DEPTH-1.
    grant_log.delete();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0001;
    n = 0;
    @(negedge clk0);
    while (!(bus.dbg_fifo_count == 6 && bus.dbg_inflight == 2) && n < 40) begin
      n++;
      @(negedge clk0);
    end
    if (n >= 40) fail_timeout("fill_wait");
    tick();
    bus.resp_ready = 1'b1;
    chk("accepted_when_full", 64'(grant_log.size()), 64'(DEPTH));
    chk("stall_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clk0);
    tick();
    @(negedge clk0);
    chk("push_pop_count", 64'(bus.dbg_fifo_count), 64'(DEPTH - 1));
    chk("resume_ready", 64'(bus.req_ready), 64'(1));
    run_cycles(6, 1'b0, 4'b0001);
    drain();

    // Randomized traffic.
    run_cycles(1500, 1'b1, '0);
    drain();

    // Reset with 3 in flight and 2 buffered discards everything.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0001;
    repeat (5) tick();
    bus.req_valid = '0;
    n = 0;
    @(negedge clk0);
    while (!(bus.dbg_inflight == 3 && bus.dbg_fifo_count == 2) && n < 20) begin
      n++;
      @(negedge clk0);
    end
    if (n >= 20) fail_timeout("midop_wait");
    #1;
    clr0 = 1'b0;
    #1;
    chk("midop_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("midop_busy", 64'(bus.busy), 64'(0));
    repeat (2) tick();
    clr0 = 1'b1;
    bus.resp_ready = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge clk0);
      if (bus.resp_valid) stale++;
    end
    chk("no_stale_resp", 64'(stale), 64'(0));

    // Traffic after the mid-operation reset.
    run_cycles(300, 1'b1, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002: Parameter LATENCY, default 4, fixed multiplier latency in cycles; shall equal the attached multiplier's latency.
REQ-003: Parameter FIFO_DEPTH, default 8, response buffer entries (power of two, >= LATENCY).
REQ-004: Parameter ID_W, default $clog2(NUM_REQ), requester-id width.
REQ-005: clk0  input  1  sole clock; all state on rising edge.
REQ-006: clr0  input  1  asynchronous active-low reset.
REQ-007: req_valid  input  NUM_REQ  per-requester operation request.
REQ-008: req_ready  output  NUM_REQ  per-requester accept; transfer when valid and ready are both high.
REQ-009: req_a  input  32*NUM_REQ  operand A, requester i in bits [32i+31:32i].
REQ-010: req_b  input  32*NUM_REQ  operand B, same packing.
REQ-011: mul_ay  output  32  operand A to the multiplier.
REQ-012: mul_az  output  32  operand B to the multiplier.
REQ-013: mul_result  input  32  multiplier result, valid LATENCY cycles after issue.
REQ-014: resp_valid  output  1  response available.
REQ-015: resp_ready  input  1  consumer accepts the response.
REQ-016: resp_id  output  ID_W  index of the requester that owns resp_data.
REQ-017: resp_data  output  32  product.
REQ-018: busy  output  1  high while any operation is in flight or buffered.

Function
REQ-019: Arbitration shall be round-robin: grant the lowest index i >= rr_ptr with req_valid high, wrapping to 0..rr_ptr-1 when none is found.
REQ-020: req_ready shall be one-hot on the granted index when credit is available, and all-zero otherwise; req_ready shall not depend combinationally on resp_ready.
REQ-021: Credit shall be available when inflight + fifo_count < FIFO_DEPTH, where inflight counts valid stages of the tag pipe.
REQ-022: On issue, mul_ay/mul_az shall carry the granted operands in the same cycle, and rr_ptr shall become (grant+1) mod NUM_REQ at the next edge.
REQ-023: With no issue, rr_ptr shall hold and mul_ay/mul_az shall be driven to 0.
REQ-024: A LATENCY-stage tag pipe (valid bit plus ID) shall shift every cycle; the stage issued at cycle t shall exit at cycle t+LATENCY.
REQ-025: When a valid tag exits, {id, mul_result} shall be written into the FIFO that same cycle.
REQ-026: Credit accounting shall guarantee the FIFO is never full on a tag exit, so results are never dropped.
REQ-027: resp_valid shall equal FIFO not-empty; resp_id and resp_data shall present the FIFO head; pop occurs on resp_valid && resp_ready.
REQ-028: Responses shall leave in issue order.
REQ-029: Simultaneous push and pop shall leave fifo_count unchanged; pointers shall wrap modulo FIFO_DEPTH.
REQ-030: The block shall sustain one issue per cycle while resp_ready stays high.
REQ-031: The minimum latency from request transfer to resp_valid shall be LATENCY+1 cycles, because the FIFO write is registered.
REQ-032: busy shall equal (inflight != 0) || (fifo_count != 0).
REQ-033: The multiplier's enable shall be tied high and its clear held inactive.

Reset
REQ-034: While clr0 is low, rr_ptr, the tag-pipe valid bits, FIFO pointers and counts shall be 0, resp_valid 0 and busy 0.
REQ-035: resp_id and resp_data shall be 0 during reset.
REQ-036: req_ready shall be all-zero during reset.
REQ-037: Reset asserted mid-operation shall discard all in-flight and buffered results; no response for them shall appear after release.
REQ-038: The first grant after reset shall go to requester 0 if it is valid.

Verification
REQ-039: Single request: req 2 sends a=0x40000000 (2.0), b=0x40400000 (3.0), resp_ready=1 -> resp_valid high 5 cycles after the transfer with resp_id=2 and resp_data=0x40C00000 (6.0).
REQ-040: All 4 requesters valid continuously from reset -> grants 0,1,2,3,0,... one per cycle, and responses return in the same order with matching products.
REQ-041: resp_ready=0 with requester 0 streaming -> exactly 8 transfers accepted, then req_ready stays 0; raising resp_ready drains 8 responses in order, and issue resumes the cycle credit frees.
REQ-042: FIFO at depth-1 with a simultaneous tag exit and pop -> fifo_count unchanged, no loss, no duplicate.
REQ-043: clr0 pulsed low with 3 in flight and 2 buffered -> resp_valid=0 and busy=0 immediately, and no stale response after release.
REQ-044: Requesters 1 and 3 valid with rr_ptr=2 -> grant goes to 3, then to 1.
